// File: rtl/hex_display_scanner.sv
// Four-digit multiplexed hex display scanner.
// Cycles an active-low anode enable across four digits, presents the active
// nibble for an external 7-segment decoder, and double-buffers new values so
// the display only changes on a frame boundary (3->0 digit wrap).
module hex_display_scanner #(
  parameter int unsigned DIV           = 50000,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  output logic        ready,
  output logic [3:0]  hex_digit,
  output logic [3:0]  digit_en,
  output logic        frame_tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0] pcnt, pcnt_n;
  logic [1:0]    idx, idx_n;
  logic [15:0]   disp, disp_n;
  logic [15:0]   shad, shad_n;
  logic          pending, pending_n;
  logic          step, wrap, accept, commit;
  logic [3:0]    blank;
  logic [3:0]    hex_n, en_n;
  logic          tick_n;

  // Shadow buffer is free whenever no update is waiting for a frame boundary.
  assign ready = !pending;

  // Next-state logic: prescaler, digit index, double buffer and output decode.
  always_comb begin
    pcnt_n    = pcnt;
    idx_n     = idx;
    disp_n    = disp;
    shad_n    = shad;
    pending_n = pending;
    blank     = 4'b0000;
    hex_n     = 4'h0;
    en_n      = 4'hF;
    tick_n    = 1'b0;

    step   = (pcnt == PMAX);
    wrap   = step && (idx == 2'd3);
    accept = load && !pending;
    commit = wrap && pending;

    pcnt_n = step ? '0 : PW'(pcnt + 1'b1);
    if (step) begin
      idx_n = idx + 2'd1;
    end

    // Accept and commit are mutually exclusive since they need opposite pending.
    if (accept) begin
      shad_n    = value;
      pending_n = 1'b1;
    end
    if (commit) begin
      disp_n    = shad;
      pending_n = 1'b0;
    end

    // Leading-zero suppression looks at the value being shown after any commit.
    if (BLANK_LEADING != 0) begin
      blank[1] = (disp_n[15:4] == 12'h000);
      blank[2] = (disp_n[15:8] == 8'h00);
      blank[3] = (disp_n[15:12] == 4'h0);
    end

    hex_n  = disp_n[{idx_n, 2'b00} +: 4];
    en_n   = blank[idx_n] ? 4'hF : ~(4'b0001 << idx_n);
    tick_n = wrap;
  end

  // State and registered outputs; reset restarts scanning at digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt       <= '0;
      idx        <= 2'd0;
      disp       <= 16'h0000;
      shad       <= 16'h0000;
      pending    <= 1'b0;
      hex_digit  <= 4'h0;
      digit_en   <= 4'b1110;
      frame_tick <= 1'b0;
    end else begin
      pcnt       <= pcnt_n;
      idx        <= idx_n;
      disp       <= disp_n;
      shad       <= shad_n;
      pending    <= pending_n;
      hex_digit  <= hex_n;
      digit_en   <= en_n;
      frame_tick <= tick_n;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: one instance with leading-zero blanking and
// one without, driven in lockstep with DIV=4 (16-cycle frames).
module tb_hex_display_scanner;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;

  logic        ready, ready2;
  logic [3:0]  hex_digit, hex_digit2;
  logic [3:0]  digit_en, digit_en2;
  logic        frame_tick, frame_tick2;

  int checks = 0;
  int failures = 0;

  hex_display_scanner #(.DIV(DIV), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .ready(ready), .hex_digit(hex_digit), .digit_en(digit_en),
    .frame_tick(frame_tick)
  );

  hex_display_scanner #(.DIV(DIV), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .ready(ready2), .hex_digit(hex_digit2), .digit_en(digit_en2),
    .frame_tick(frame_tick2)
  );

  always #5 clk = ~clk;

  // Expected per-digit display, queued when a value is loaded.
  typedef struct packed {
    logic [3:0] hex;
    logic [3:0] en_b;
    logic [3:0] en_nb;
  } dig_t;
  dig_t exp_q[$];

  typedef struct {
    logic [15:0] value;
    logic [15:0] en_b;   // blanked-instance enable for digit k in [4k+:4]
  } vec_t;
  vec_t vecs[7];
  logic [3:0] en_nb_tab[4];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [15:0] enb);
    for (int d = 0; d < 4; d++) begin
      dig_t e;
      e.hex   = v[4*d +: 4];
      e.en_b  = enb[4*d +: 4];
      e.en_nb = en_nb_tab[d];
      exp_q.push_back(e);
    end
  endtask

  // Wait (bounded) for a frame_tick at the current or a later negedge.
  task automatic wait_tick(input string tag);
    int n = 0;
    while (!frame_tick && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tick_seen"}, 16'(frame_tick), 16'h1);
  endtask

  // Check one full frame starting at a frame_tick against queued expectations.
  task automatic run_frame(input string tag);
    wait_tick(tag);
    for (int d = 0; d < 4; d++) begin
      dig_t e;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_queue_empty actual=0 required=4", tag);
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("%s_d%0d_c%0d_hex", tag, d, c), 16'(hex_digit), 16'(e.hex));
        chk($sformatf("%s_d%0d_c%0d_en", tag, d, c), 16'(digit_en), 16'(e.en_b));
        chk($sformatf("%s_d%0d_c%0d_en_nb", tag, d, c), 16'(digit_en2), 16'(e.en_nb));
        chk($sformatf("%s_d%0d_c%0d_tick", tag, d, c), 16'(frame_tick),
            16'(d == 0 && c == 0));
        if (d == 0 && c == 0) chk({tag, "_ready_at_commit"}, 16'(ready), 16'h1);
        @(negedge clk);
      end
    end
    chk({tag, "_next_tick"}, 16'(frame_tick), 16'h1);
  endtask

  // Load a value through the handshake and verify the frame that shows it.
  task automatic load_val(input logic [15:0] v, input logic [15:0] enb, input string tag);
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_before"}, 16'(ready), 16'h1);
    load  = 1'b1;
    value = v;
    push_frame(v, enb);
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_pending"}, 16'(ready), 16'h0);
    @(negedge clk);
    run_frame(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    en_nb_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
    vecs[0] = '{16'h1234, 16'h7BDE};
    vecs[1] = '{16'h00F0, 16'hFFDE};
    vecs[2] = '{16'h0000, 16'hFFFE};
    vecs[3] = '{16'h0100, 16'hFBDE};
    vecs[4] = '{16'h000A, 16'hFFFE};
    vecs[5] = '{16'h0010, 16'hFFDE};
    vecs[6] = '{16'hF000, 16'h7BDE};

    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1;
    chk("rst_hex", 16'(hex_digit), 16'h0);
    chk("rst_en", 16'(digit_en), 16'hE);
    chk("rst_tick", 16'(frame_tick), 16'h0);
    chk("rst_ready", 16'(ready), 16'h1);
    chk("rst_en_nb", 16'(digit_en2), 16'hE);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven values, including scan order and blanking cases.
    for (int i = 0; i < 7; i++) begin
      load_val(vecs[i].value, vecs[i].en_b, $sformatf("vec%0d", i));
    end

    // Handshake: second load while busy is ignored.
    load  = 1'b1;
    value = 16'hABCD;
    push_frame(16'hABCD, 16'h7BDE);
    @(posedge clk);
    #1 value = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hs_busy%0d", i), 16'(ready), 16'h0);
    end
    load = 1'b0;
    @(negedge clk);
    run_frame("hs");
    push_frame(16'hABCD, 16'h7BDE);
    run_frame("hs_hold");

    // Boundary: accept on the cycle before the 3->0 step, commit one edge later.
    repeat (14) @(negedge clk);
    load  = 1'b1;
    value = 16'h0007;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    chk("bnd_ready", 16'(ready), 16'h0);
    chk("bnd_tick_before", 16'(frame_tick), 16'h0);
    chk("bnd_hex_before", 16'(hex_digit), 16'hA);
    chk("bnd_en_before", 16'(digit_en), 16'h7);
    @(negedge clk);
    chk("bnd_tick", 16'(frame_tick), 16'h1);
    chk("bnd_hex_after", 16'(hex_digit), 16'h7);
    push_frame(16'h0007, 16'hFFFE);
    run_frame("bnd");

    // Reset while an update is pending discards it.
    load  = 1'b1;
    value = 16'h5555;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    chk("rstp_pending", 16'(ready), 16'h0);
    #2 rst = 1'b1;
    #1;
    chk("rstp_ready", 16'(ready), 16'h1);
    chk("rstp_hex", 16'(hex_digit), 16'h0);
    chk("rstp_en", 16'(digit_en), 16'hE);
    chk("rstp_tick", 16'(frame_tick), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstp_hold%0d", i), 16'(digit_en2), 16'hE);
      chk($sformatf("rstp_notick%0d", i), 16'(frame_tick), 16'h0);
    end
    @(negedge clk);
    chk("rstp_first_step_nb", 16'(digit_en2), 16'hD);
    chk("rstp_first_step_b", 16'(digit_en), 16'hF);
    chk("rstp_first_step_hex", 16'(hex_digit), 16'h0);
    chk("rstp_ready_after", 16'(ready), 16'h1);
    push_frame(16'h0000, 16'hFFFE);
    run_frame("rstp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 SHALL have parameter DIV, default 50000: clock cycles each digit stays lit; legal range 2..2^20.
REQ-002 SHALL have parameter BLANK_LEADING, default 1: 1 enables leading-zero suppression, 0 disables it.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; the clock port is `clk`, the reset port is `rst`, and all state is clocked on the rising edge of `clk`.
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port load  input  1  request to capture value.
REQ-007 SHALL have port value  input  16  four hex nibbles; [3:0] is digit 0 (rightmost).
REQ-008 SHALL have port ready  output  1  high when load is accepted.
REQ-009 SHALL have port hex_digit  output  4  nibble for the active digit; it feeds hexTo7Seg.hex_input.
REQ-010 SHALL have port digit_en  output  4  active-low one-hot anode enables; bit k is digit k.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse on each 3->0 digit wrap.

Function
REQ-012 SHALL hold a prescale counter pcnt that counts 0..DIV-1 and wraps to 0; step = the cycle where pcnt==DIV-1.
REQ-013 SHALL hold a 2-bit digit index idx that advances on each step: 0->1->2->3->0.
REQ-014 SHALL hold a 16-bit display register disp and a 16-bit shadow register shad, plus a pending flag.
REQ-015 SHALL define ready = !pending (combinational).
REQ-016 SHALL treat load && ready as an accept: shad <= value and pending <= 1 at the next edge.
REQ-017 SHALL ignore load while ready is 0; shad is unchanged and no error is flagged.
REQ-018 SHALL perform a commit on the step where idx goes 3->0 with pending==1: disp <= shad and pending <= 0 in the same edge.
REQ-019 SHALL let a display update take effect only at a frame boundary; a digit never shows a mix of old and new values within one frame.
REQ-020 SHALL handle accept and commit in the same cycle without conflict: ready is 0 in that cycle, so no accept can occur.
REQ-021 SHALL register hex_digit, digit_en and frame_tick; they change on the same edge that idx changes.
REQ-022 SHALL drive hex_digit = disp nibble idx, using the disp value after any commit on that edge.
REQ-023 SHALL drive digit_en = ~(1<<idx), except all ones (digit dark) when the digit is blanked.
REQ-024 SHALL blank digit k, when BLANK_LEADING==1, for k in 1..3 iff disp nibbles k..3 are all zero; digit 0 is never blanked.
REQ-025 SHALL still drive the nibble on hex_digit when a digit is blanked.
REQ-026 SHALL pulse frame_tick high for exactly one cycle, coincident with idx becoming 0 after a step; it is 0 otherwise.
REQ-027 SHALL give a load-to-display latency from accept to the next 3->0 wrap: min 1 cycle, max 4*DIV cycles.
REQ-028 SHALL have pcnt and idx run freely and be unaffected by load or commit.

Reset
REQ-029 SHALL, while rst is high, immediately force pcnt=0, idx=0, disp=0, shad=0, pending=0, hex_digit=0, digit_en=4'b1110 and frame_tick=0; ready therefore reads 1.
REQ-030 SHALL, on reset mid-frame or with an update pending, discard the pending value; after release, scanning restarts at digit 0 with count 0.
REQ-031 SHALL reach the first step DIV cycles after the first rising edge following rst deassertion.

Verification (DIV=4, BLANK_LEADING=1 unless stated)
REQ-032 SHALL cover reset: assert rst asynchronously between edges -> outputs take reset values before the next edge; digit_en=1110, hex_digit=0, ready=1.
REQ-033 SHALL cover scan order: after reset, load 16'h1234 and wait one frame -> digit_en sequence 1110,1101,1011,0111, each held 4 cycles, with hex_digit 4,3,2,1; frame_tick pulses every 16 cycles.
REQ-034 SHALL cover handshake: load 16'hABCD accepted, then load 16'h0000 while ready=0 -> the second load is ignored; the next frame shows D,C,B,A and ready returns to 1 on the commit edge.
REQ-035 SHALL cover blanking: display 16'h00F0 -> digit 3 and digit 2 enables stay 1111; digits 1 and 0 show F and 0; value 16'h0000 -> only digit 0 is lit, showing 0; with BLANK_LEADING=0, all four digits are lit.
REQ-036 SHALL cover boundary load: accept on the cycle before the 3->0 step -> commit occurs on the next edge, latency 1.
REQ-037 SHALL cover reset during pending: accept 16'h5555, assert rst before the commit -> disp stays 0 and ready=1 after release.
